// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture block: segment patterns,
// sampler state type, sample layout and small helpers.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110010;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [0:0] {
        ST_TRACK  = 1'b0,
        ST_LOCKED = 1'b1
    } samp_state_e;

    typedef struct packed {
        logic [3:0] an_n;
        logic [6:0] seg;
    } sample_t;

    // Idle bus: no strobe active, all segments dark.
    localparam sample_t SAMPLE_RST = '{an_n: 4'hF, seg: 7'h00};

    function automatic logic single_low(input logic [3:0] an);
        logic hit;
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'hF) begin
            r = v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD decoder; unknown patterns give
// BCD_INVALID with err raised.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);

    // Pattern lookup
    always_comb begin
        bcd = BCD_INVALID;
        err = 1'b1;
        case (seg)
            SEG_0: begin bcd = 4'd0; err = 1'b0; end
            SEG_1: begin bcd = 4'd1; err = 1'b0; end
            SEG_2: begin bcd = 4'd2; err = 1'b0; end
            SEG_3: begin bcd = 4'd3; err = 1'b0; end
            SEG_4: begin bcd = 4'd4; err = 1'b0; end
            SEG_5: begin bcd = 4'd5; err = 1'b0; end
            SEG_6: begin bcd = 4'd6; err = 1'b0; end
            SEG_7: begin bcd = 4'd7; err = 1'b0; end
            SEG_8: begin bcd = 4'd8; err = 1'b0; end
            SEG_9: begin bcd = 4'd9; err = 1'b0; end
            default: begin bcd = BCD_INVALID; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Captures a multiplexed 4-digit seven-segment display into BCD frames with
// a valid/ready output handshake and a sticky overrun flag.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_n,
    output logic [15:0] bcd_out,
    output logic [3:0]  err_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun
);

    // Counter value seen on the cycle whose edge completes the dwell; the two
    // synchronizer edges already account for part of the required stability.
    localparam logic [3:0] CAP_COUNT = 4'(STABLE_CYCLES - 32'd2);

    sample_t           raw_s;
    sample_t           sync1_q;
    sample_t           sync2_q;
    sample_t           prev_q;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    samp_state_e       state_q;
    samp_state_e       state_d;

    logic              strobed_s;
    logic              same_s;
    logic              cap_hit_s;
    logic              capture_s;
    logic [1:0]        slot_idx_s;
    logic [3:0]        cap_mask_s;
    logic [3:0]        dec_bcd_s;
    logic              dec_err_s;

    logic [3:0][3:0]   slot_bcd_q;
    logic [3:0]        slot_err_q;
    logic [3:0]        fill_q;
    logic [3:0]        fill_d;

    logic              frame_done_s;
    logic              load_s;
    logic              drop_s;
    logic [15:0]       bcd_q;
    logic [15:0]       bcd_d;
    logic [3:0]        err_q;
    logic [3:0]        err_d;
    logic              valid_q;
    logic              valid_d;
    logic              overrun_q;
    logic              overrun_d;

    assign raw_s = {an_n, seg_in};

    // Two-flop synchronizer, previous-sample register and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= SAMPLE_RST;
            sync2_q <= SAMPLE_RST;
            prev_q  <= SAMPLE_RST;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    assign strobed_s  = single_low(sync2_q.an_n);
    assign same_s     = (sync2_q == prev_q);
    assign slot_idx_s = low_index(sync2_q.an_n);

    // Stability counter next value
    always_comb begin
        cnt_d = 4'd0;
        if (strobed_s && same_s) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = 4'd0;
        end
    end

    assign cap_hit_s = strobed_s && (cnt_d == CAP_COUNT);

    // Sampler state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_TRACK;
        end else begin
            state_q <= state_d;
        end
    end

    // Sampler next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TRACK: begin
                if (cap_hit_s) begin
                    state_d = ST_LOCKED;
                end else begin
                    state_d = ST_TRACK;
                end
            end
            ST_LOCKED: begin
                // With the shortest dwell a fresh sample may complete on its
                // very first cycle, so a change can re-lock immediately.
                if (!same_s) begin
                    state_d = cap_hit_s ? ST_LOCKED : ST_TRACK;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: state_d = ST_TRACK;
        endcase
    end

    // Sampler outputs
    always_comb begin
        capture_s = 1'b0;
        case (state_q)
            ST_TRACK:  capture_s = cap_hit_s;
            ST_LOCKED: capture_s = !same_s && cap_hit_s;
            default:   capture_s = 1'b0;
        endcase
    end

    seg7_to_bcd u_dec (
        .seg (sync2_q.seg),
        .bcd (dec_bcd_s),
        .err (dec_err_s)
    );

    // Slot storage; newest capture into a slot wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_bcd_q <= 16'h0000;
            slot_err_q <= 4'h0;
        end else if (capture_s) begin
            slot_bcd_q[slot_idx_s] <= dec_bcd_s;
            slot_err_q[slot_idx_s] <= dec_err_s;
        end else begin
            slot_bcd_q <= slot_bcd_q;
            slot_err_q <= slot_err_q;
        end
    end

    assign frame_done_s = &fill_q;
    assign cap_mask_s   = capture_s ? (4'b0001 << slot_idx_s) : 4'b0000;
    assign fill_d       = (frame_done_s ? 4'h0 : fill_q) | cap_mask_s;

    // Slot-filled flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= 4'h0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign load_s = frame_done_s && (!valid_q || out_ready);
    assign drop_s = frame_done_s && valid_q && !out_ready;

    // Output handshake next-state
    always_comb begin
        bcd_d     = bcd_q;
        err_d     = err_q;
        valid_d   = valid_q;
        overrun_d = overrun_q | drop_s;
        if (load_s) begin
            bcd_d   = slot_bcd_q;
            err_d   = slot_err_q;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q     <= 16'h0000;
            err_q     <= 4'h0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            bcd_q     <= bcd_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign err_out   = err_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: expected frames are queued as digits are
// driven and compared whenever the DUT hands a frame over.
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_n;
    logic [15:0] bcd_out;
    logic [3:0]  err_out;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cycles = 0;
    int v0;
    int lat;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110010,
                             7'b1111111, 7'b1111011};

    always #5 clk = ~clk;

    seg7_capture #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .an_n      (an_n),
        .bcd_out   (bcd_out),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n);
        an_n   = an;
        seg_in = sg;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic digit(input int slot, input int d, input int n);
        logic [3:0] m;
        m = 4'b0001 << slot;
        drive(~m, pat[d], n);
    endtask

    // Frame monitor: every accepted frame is checked against the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            valid_cycles++;
            if (out_ready === 1'b1) begin
                check_val("frame_present", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_val("frame_bcd", {16'd0, bcd_out}, {16'd0, mon_e[19:4]});
                    check_val("frame_err", {28'd0, err_out}, {28'd0, mon_e[3:0]});
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        an_n      = 4'hF;
        seg_in    = 7'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_bcd", {16'd0, bcd_out}, 32'h0000);
        check_val("rst_err", {28'd0, err_out}, 32'h0);
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        drive(4'hF, 7'h00, 3);

        // Nominal frame plus fourth-capture-to-valid latency
        exp_q.push_back({16'h4321, 4'h0});
        v0 = valid_cycles;
        digit(0, 1, 6);
        digit(1, 2, 6);
        digit(2, 3, 6);
        an_n   = 4'b0111;
        seg_in = pat[4];
        lat    = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (out_valid && lat == 0) lat = i;
        end
        @(posedge clk);
        #2;
        check_val("nominal_latency", lat, 32'd7);
        drive(4'hF, 7'h00, 4);
        check_val("nominal_pulses", valid_cycles - v0, 32'd1);

        // Glitching slot 0 must not complete the frame early
        exp_q.push_back({16'h8883, 4'h0});
        v0 = valid_cycles;
        digit(1, 8, 6);
        digit(2, 8, 6);
        digit(3, 8, 6);
        for (int i = 0; i < 6; i++) begin
            digit(0, 0, 2);
            digit(0, 1, 2);
        end
        digit(0, 3, 6);
        drive(4'hF, 7'h00, 4);
        check_val("glitch_pulses", valid_cycles - v0, 32'd1);

        // Undecodable pattern in slot 2
        exp_q.push_back({16'h8F88, 4'b0100});
        digit(0, 8, 6);
        digit(1, 8, 6);
        drive(4'b1011, 7'b0000001, 6);
        digit(3, 8, 6);
        drive(4'hF, 7'h00, 4);

        // Overwrite of slot 1, then strobe faults before the last slot
        exp_q.push_back({16'h5595, 4'h0});
        v0 = valid_cycles;
        digit(1, 7, 6);
        digit(1, 9, 6);
        digit(2, 5, 6);
        digit(3, 5, 6);
        drive(4'b1100, pat[8], 10);
        drive(4'b1111, pat[8], 10);
        check_val("strobe_fault_pulses", valid_cycles - v0, 32'd0);
        digit(0, 5, 6);
        drive(4'hF, 7'h00, 4);

        // Backpressure: second frame is dropped and overrun latches
        out_ready = 1'b0;
        exp_q.push_back({16'h5555, 4'h0});
        for (int s = 0; s < 4; s++) digit(s, 5, 6);
        drive(4'hF, 7'h00, 3);
        check_val("bp_valid", {31'd0, out_valid}, 32'd1);
        check_val("bp_first", {16'd0, bcd_out}, 32'h5555);
        check_val("bp_no_overrun", {31'd0, overrun}, 32'd0);
        for (int s = 0; s < 4; s++) digit(s, 6, 6);
        drive(4'hF, 7'h00, 4);
        check_val("bp_held", {16'd0, bcd_out}, 32'h5555);
        check_val("bp_held_err", {28'd0, err_out}, 32'h0);
        check_val("bp_overrun", {31'd0, overrun}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        check_val("bp_valid_drop", {31'd0, out_valid}, 32'd0);
        check_val("bp_bcd_hold", {16'd0, bcd_out}, 32'h5555);
        drive(4'hF, 7'h00, 4);
        check_val("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-frame discards everything
        digit(0, 2, 6);
        digit(1, 2, 6);
        digit(2, 2, 6);
        rst_n  = 1'b0;
        an_n   = 4'hF;
        seg_in = 7'h00;
        #1;
        check_val("mid_rst_bcd", {16'd0, bcd_out}, 32'h0000);
        check_val("mid_rst_err", {28'd0, err_out}, 32'h0);
        check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(4'hF, 7'h00, 2);
        v0 = valid_cycles;
        digit(3, 7, 6);
        drive(4'hF, 7'h00, 10);
        check_val("rst_no_partial", valid_cycles - v0, 32'd0);
        exp_q.push_back({16'h7111, 4'h0});
        digit(0, 1, 6);
        digit(1, 1, 6);
        digit(2, 1, 6);
        drive(4'hF, 7'h00, 4);
        check_val("rst_frame_pulses", valid_cycles - v0, 32'd1);

        check_val("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset. Parameters and ports are:
- STABLE_CYCLES, 4, number of consecutive identical synchronized samples required before a digit is captured (legal range 2..15).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  active-high segment lines [6:0] = a,b,c,d,e,f,g.
- an_n  input  4  active-low digit strobes; bit i selects digit slot i.
- bcd_out  output  16  captured frame; slot i in bits [4i+3:4i].
- err_out  output  4  bit i set when slot i held an undecodable pattern.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts frame.
- overrun  output  1  sticky flag: a completed frame was dropped.

Function
REQ-002 seg_in and an_n SHALL pass through a two-flop synchronizer; all following logic SHALL use only the synchronized values.
REQ-003 A sample SHALL count as "strobed" only when exactly one an_n bit is 0. Zero or multiple low bits SHALL clear the stability counter and capture nothing.
REQ-004 The stability counter SHALL increment while the synchronized {an_n, seg_in} equals the previous cycle's value. It SHALL reset to 0 on any change.
REQ-005 The sampler FSM SHALL have states TRACK and LOCKED. In TRACK, on the edge where a strobed sample has been identical for STABLE_CYCLES consecutive cycles, the FSM SHALL capture the sample into the selected slot and move to LOCKED.
REQ-006 In LOCKED, the FSM SHALL return to TRACK on any change of {an_n, seg_in}. Each dwell SHALL produce at most one capture.
REQ-007 Decode SHALL map patterns (a..g, MSB first) to BCD values:
- 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
- 5 = 1011011, 6 = 1011111, 7 = 1110010, 8 = 1111111, 9 = 1111011
Any other pattern SHALL store 4'hF and set that slot's error bit.
REQ-008 A capture into an already-filled slot SHALL overwrite its value and error bit with the newest capture.
REQ-009 When all four slot-filled flags are set, frame completion SHALL clear them in the same cycle.
REQ-010 On frame completion, the module SHALL load the frame if out_valid=0, or if out_valid=1 and out_ready=1 in the same cycle. bcd_out and err_out SHALL update and out_valid SHALL be 1 on the next cycle.
REQ-011 If a frame completes while out_valid=1 and out_ready=0, the module SHALL discard the new frame, keep the held frame unchanged, and set overrun.
REQ-012 When out_valid=1 and out_ready=1 with no frame completing, out_valid SHALL drop next cycle. bcd_out and err_out SHALL hold their last values.
REQ-013 bcd_out and err_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-014 Latency SHALL be:
- input change to capture: 2 + STABLE_CYCLES - 1 edges;
- fourth capture to out_valid high: 1 cycle.

Reset
REQ-015 Asserting rst_n low SHALL immediately set:
- bcd_out = 16'h0000, err_out = 4'h0, out_valid = 0, overrun = 0;
- slot flags cleared, counter 0, FSM in TRACK, synchronizers all-ones on an_n and zero on seg_in.
REQ-016 Reset asserted mid-frame or mid-handshake SHALL discard all partial and held data. After release, the first frame SHALL require four fresh captures.
REQ-017 overrun SHALL clear only by reset.

Structure
REQ-018 Shared package seg7_pkg SHALL hold the ten segment-pattern constants, BCD_INVALID = 4'hF, and the sampler state typedef.
REQ-019 Pattern decode SHALL be a separate combinational sub-module seg7_to_bcd (seg[6:0] in; bcd[3:0] and err out), instantiated once.

Verification
REQ-020 Nominal frame: with STABLE_CYCLES=4, drive an_n=1110/1101/1011/0111 with digits 1,2,3,4, each held 6 cycles, out_ready=1 -> one out_valid pulse, bcd_out=16'h4321, err_out=0.
REQ-021 Glitch rejection: slot 0 pattern toggles 1111110/0110000 every 2 cycles, then settles on 1111001 for 6 cycles -> slot 0 captures 3 only; no capture of 0 or 1.
REQ-022 Invalid pattern: slot 2 = 0000001, other slots = 8 -> bcd_out=16'h8F88, err_out=4'b0100.
REQ-023 Backpressure: out_ready=0, two complete frames (5555 then 6666) -> bcd_out stays 16'h5555, overrun=1. Then out_ready=1 -> out_valid drops next cycle.
REQ-024 Strobe faults and overwrite: an_n=1100 or 1111 held 10 cycles -> no capture. Slot 1 captured as 7 then 9 before frame completes -> bcd_out[7:4]=9.
REQ-025 Reset mid-frame: capture three slots, pulse rst_n low -> all outputs 0 at once. A frame after release needs all four slots.
